// File: rtl/codec_regs_pkg.sv
// Shared types and constants for the I2C-controlled codec register block:
// FSM state encoding, the register-file reset address and the power-on register values.
package codec_regs_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DEVADDR = 3'd1,
        DEVACK  = 3'd2,
        BYTE1   = 3'd3,
        ACK1    = 3'd4,
        BYTE2   = 3'd5,
        ACK2    = 3'd6,
        IGNORE  = 3'd7
    } i2c_state_e;

    localparam logic [6:0] REG_RESET_ADDR = 7'h0F;
    localparam int         NUM_DEFAULTS   = 10;

    // Power-on value of codec register Rn; registers beyond the table default to zero.
    function automatic logic [8:0] reg_default(input logic [6:0] idx);
        logic [8:0] val;
        case (idx)
            7'd0:    val = 9'h097;
            7'd1:    val = 9'h097;
            7'd2:    val = 9'h079;
            7'd3:    val = 9'h079;
            7'd4:    val = 9'h00A;
            7'd5:    val = 9'h008;
            7'd6:    val = 9'h09F;
            7'd7:    val = 9'h00A;
            7'd8:    val = 9'h000;
            7'd9:    val = 9'h000;
            default: val = 9'h000;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings the asynchronous I2C pins into the clk domain and produces registered
// one-cycle START, STOP, SCLK-rise and SCLK-fall pulses plus the aligned SDAT level.
module i2c_bus_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic i2c_sclk,
    input  logic i2c_sdat_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic bus_start,
    output logic bus_stop,
    output logic sda_bit
);

    logic scl_meta_r;
    logic scl_sync_r;
    logic scl_dly_r;
    logic sda_meta_r;
    logic sda_sync_r;
    logic sda_dly_r;
    logic scl_rise_r;
    logic scl_fall_r;
    logic start_r;
    logic stop_r;
    logic sda_bit_r;

    // Two-flop synchronizers, one-cycle delayed copies and registered edge/condition pulses.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            scl_meta_r <= 1'b1;
            scl_sync_r <= 1'b1;
            scl_dly_r  <= 1'b1;
            sda_meta_r <= 1'b1;
            sda_sync_r <= 1'b1;
            sda_dly_r  <= 1'b1;
            scl_rise_r <= 1'b0;
            scl_fall_r <= 1'b0;
            start_r    <= 1'b0;
            stop_r     <= 1'b0;
            sda_bit_r  <= 1'b1;
        end else begin
            scl_meta_r <= i2c_sclk;
            scl_sync_r <= scl_meta_r;
            scl_dly_r  <= scl_sync_r;
            sda_meta_r <= i2c_sdat_in;
            sda_sync_r <= sda_meta_r;
            sda_dly_r  <= sda_sync_r;
            scl_rise_r <= scl_sync_r & ~scl_dly_r;
            scl_fall_r <= ~scl_sync_r & scl_dly_r;
            // SDAT may only move while SCLK is low; a change with SCLK high is START/STOP.
            start_r    <= scl_sync_r & scl_dly_r & sda_dly_r & ~sda_sync_r;
            stop_r     <= scl_sync_r & scl_dly_r & ~sda_dly_r & sda_sync_r;
            sda_bit_r  <= sda_sync_r;
        end
    end

    assign scl_rise  = scl_rise_r;
    assign scl_fall  = scl_fall_r;
    assign bus_start = start_r;
    assign bus_stop  = stop_r;
    assign sda_bit   = sda_bit_r;

endmodule

// File: rtl/i2c_codec_regs.sv
// Write-only I2C target holding the 9-bit codec control registers: a two-byte
// write {addr[6:0], data[8]}, {data[7:0]} commits one register.
module i2c_codec_regs
    import codec_regs_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h1A,
    parameter int         NUM_REGS = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i2c_sclk,
    input  logic                  i2c_sdat_in,
    output logic                  i2c_sdat_oe,
    output logic                  reg_wr,
    output logic [6:0]            reg_addr,
    output logic [8:0]            reg_data,
    output logic [9*NUM_REGS-1:0] regs,
    output logic                  bad_addr
);

    localparam logic [7:0] NUM_REGS_A = 8'(NUM_REGS);

    logic scl_rise;
    logic scl_fall;
    logic bus_start;
    logic bus_stop;
    logic sda_bit;

    i2c_state_e state_r;
    i2c_state_e state_s;
    logic [3:0] bit_cnt_r;
    logic [3:0] bit_cnt_s;
    logic [7:0] shift_r;
    logic [7:0] shift_s;
    logic [7:0] byte1_r;
    logic [7:0] byte1_s;
    logic       oe_r;
    logic       oe_s;
    logic       commit_s;
    logic       byte_state_s;
    logic       bit_done_s;
    logic [6:0] commit_addr_s;
    logic [8:0] commit_data_s;

    logic                  reg_wr_r;
    logic [6:0]            reg_addr_r;
    logic [8:0]            reg_data_r;
    logic [9*NUM_REGS-1:0] regs_r;
    logic                  bad_addr_r;

    i2c_bus_sync u_bus_sync (
        .clk         (clk),
        .reset_n     (reset_n),
        .i2c_sclk    (i2c_sclk),
        .i2c_sdat_in (i2c_sdat_in),
        .scl_rise    (scl_rise),
        .scl_fall    (scl_fall),
        .bus_start   (bus_start),
        .bus_stop    (bus_stop),
        .sda_bit     (sda_bit)
    );

    assign byte_state_s  = (state_r == DEVADDR) || (state_r == BYTE1) || (state_r == BYTE2);
    // The ACK slot opens on the SCLK fall that closes the eighth data bit.
    assign bit_done_s    = byte_state_s && scl_fall && (bit_cnt_r == 4'd8);
    assign commit_addr_s = byte1_r[7:1];
    assign commit_data_s = {byte1_r[0], shift_r};

    // Next-state and datapath decode; START and STOP override every state.
    always_comb begin
        state_s   = state_r;
        bit_cnt_s = bit_cnt_r;
        shift_s   = shift_r;
        byte1_s   = byte1_r;
        oe_s      = oe_r;
        commit_s  = 1'b0;
        if (bus_start) begin
            state_s   = DEVADDR;
            bit_cnt_s = 4'd0;
            oe_s      = 1'b0;
        end else if (bus_stop) begin
            state_s = IDLE;
            oe_s    = 1'b0;
        end else begin
            if (byte_state_s && scl_rise && (bit_cnt_r < 4'd8)) begin
                shift_s   = {shift_r[6:0], sda_bit};
                bit_cnt_s = bit_cnt_r + 4'd1;
            end else begin
                bit_cnt_s = bit_cnt_r;
            end
            case (state_r)
                DEVADDR: begin
                    if (bit_done_s) begin
                        bit_cnt_s = 4'd0;
                        if (shift_r == {DEV_ADDR, 1'b0}) begin
                            state_s = DEVACK;
                            oe_s    = 1'b1;
                        end else begin
                            state_s = IGNORE;
                            oe_s    = 1'b0;
                        end
                    end else begin
                        state_s = DEVADDR;
                    end
                end
                BYTE1: begin
                    if (bit_done_s) begin
                        bit_cnt_s = 4'd0;
                        byte1_s   = shift_r;
                        state_s   = ACK1;
                        oe_s      = 1'b1;
                    end else begin
                        state_s = BYTE1;
                    end
                end
                BYTE2: begin
                    if (bit_done_s) begin
                        bit_cnt_s = 4'd0;
                        state_s   = ACK2;
                        oe_s      = 1'b1;
                        commit_s  = 1'b1;
                    end else begin
                        state_s = BYTE2;
                    end
                end
                DEVACK: begin
                    if (scl_fall) begin
                        state_s = BYTE1;
                        oe_s    = 1'b0;
                    end else begin
                        state_s = DEVACK;
                    end
                end
                ACK1: begin
                    if (scl_fall) begin
                        state_s = BYTE2;
                        oe_s    = 1'b0;
                    end else begin
                        state_s = ACK1;
                    end
                end
                ACK2: begin
                    // Further bytes in this transfer are left un-ACKed.
                    if (scl_fall) begin
                        state_s = IGNORE;
                        oe_s    = 1'b0;
                    end else begin
                        state_s = ACK2;
                    end
                end
                IDLE: begin
                    oe_s = 1'b0;
                end
                IGNORE: begin
                    oe_s = 1'b0;
                end
                default: begin
                    state_s = IDLE;
                    oe_s    = 1'b0;
                end
            endcase
        end
    end

    // FSM state and byte-assembly registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            bit_cnt_r <= 4'd0;
            shift_r   <= 8'h00;
            byte1_r   <= 8'h00;
            oe_r      <= 1'b0;
        end else begin
            state_r   <= state_s;
            bit_cnt_r <= bit_cnt_s;
            shift_r   <= shift_s;
            byte1_r   <= byte1_s;
            oe_r      <= oe_s;
        end
    end

    // Commit strobe, last-commit capture, register file and sticky bad-address flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            reg_wr_r   <= 1'b0;
            reg_addr_r <= 7'd0;
            reg_data_r <= 9'd0;
            bad_addr_r <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[9*i +: 9] <= reg_default(7'(i));
            end
        end else begin
            reg_wr_r <= commit_s;
            if (commit_s) begin
                reg_addr_r <= commit_addr_s;
                reg_data_r <= commit_data_s;
                if ({1'b0, commit_addr_s} < NUM_REGS_A) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (commit_addr_s == 7'(i)) begin
                            regs_r[9*i +: 9] <= commit_data_s;
                        end
                    end
                end else if (commit_addr_s == REG_RESET_ADDR) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        regs_r[9*i +: 9] <= reg_default(7'(i));
                    end
                end else begin
                    bad_addr_r <= 1'b1;
                end
            end
        end
    end

    assign i2c_sdat_oe = oe_r;
    assign reg_wr      = reg_wr_r;
    assign reg_addr    = reg_addr_r;
    assign reg_data    = reg_data_r;
    assign regs        = regs_r;
    assign bad_addr    = bad_addr_r;

endmodule

// File: tb/tb_i2c_codec_regs.sv
// Bench for i2c_codec_regs: a bit-banged I2C controller drives writes, expected
// commits go to a scoreboard queue and are matched when reg_wr pulses.
module tb_i2c_codec_regs;

    localparam int Q = 100;
    localparam int H = 200;
    localparam logic [8:0] DEF [10] = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
                                        9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000};

    logic        clk;
    logic        reset_n;
    logic        scl;
    logic        sda_m;
    logic        sda_line;
    logic        oe;
    logic        reg_wr;
    logic [6:0]  reg_addr;
    logic [8:0]  reg_data;
    logic [89:0] regs;
    logic        bad_addr;

    int          n_vec = 0;
    int          n_err = 0;
    int          oe_cnt = 0;
    int          wr_cnt = 0;
    time         last_fall = 0;
    logic [15:0] exp_q [$];
    logic [15:0] sb_e;
    logic [8:0]  model_regs [10];
    logic        model_bad;

    assign sda_line = sda_m & ~oe;

    i2c_codec_regs #(.DEV_ADDR(7'h1A), .NUM_REGS(10)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i2c_sclk    (scl),
        .i2c_sdat_in (sda_line),
        .i2c_sdat_oe (oe),
        .reg_wr      (reg_wr),
        .reg_addr    (reg_addr),
        .reg_data    (reg_data),
        .regs        (regs),
        .bad_addr    (bad_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge scl) last_fall = $time;

    // Scoreboard: every reg_wr pulse must match the oldest queued write.
    always @(negedge clk) begin
        if (oe) oe_cnt++;
        if (reg_wr) begin
            wr_cnt++;
            check_val("wr_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                sb_e = exp_q.pop_front();
                check_val("wr_addr", 32'(reg_addr), 32'(sb_e[15:9]));
                check_val("wr_data", 32'(reg_data), 32'(sb_e[8:0]));
                check_val("wr_latency", 32'($time - last_fall), 32'd40);
            end
        end
    end

    task automatic model_defaults();
        for (int i = 0; i < 10; i++) model_regs[i] = DEF[i];
    endtask

    task automatic check_state();
        for (int i = 0; i < 10; i++) begin
            check_val($sformatf("R%0d", i), 32'(regs[9*i +: 9]), 32'(model_regs[i]));
        end
        check_val("bad_addr", 32'(bad_addr), 32'(model_bad));
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; #(Q);
        scl = 1'b1;   #(H);
        sda_m = 1'b0; #(H);
        scl = 1'b0;   #(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #(Q);
        scl = 1'b1;   #(H);
        sda_m = 1'b1; #(H);
    endtask

    task automatic send_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; #(Q);
            scl = 1'b1;   #(H);
            scl = 1'b0;   #(Q);
        end
    endtask

    task automatic ack_bit(output logic a);
        sda_m = 1'b1; #(Q);
        scl = 1'b1;   #(Q);
        a = ~sda_line;
        #(Q);
        scl = 1'b0;   #(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic a);
        send_bits(b);
        ack_bit(a);
    endtask

    task automatic do_write(input logic [6:0] ra, input logic [8:0] d);
        logic a;
        int   w0;
        w0 = wr_cnt;
        i2c_start();
        send_byte(8'h34, a);
        check_val("ack_dev", 32'(a), 32'd1);
        send_byte({ra, d[8]}, a);
        check_val("ack_b1", 32'(a), 32'd1);
        exp_q.push_back({ra, d});
        send_byte(d[7:0], a);
        check_val("ack_b2", 32'(a), 32'd1);
        i2c_stop();
        check_val("wr_count", 32'(wr_cnt - w0), 32'd1);
        if (ra < 7'd10) model_regs[int'(ra)] = d;
        else if (ra == 7'h0F) model_defaults();
        else model_bad = 1'b1;
    endtask

    initial begin
        logic a;
        int   w0;
        int   o0;
        reset_n = 1'b0;
        scl = 1'b1;
        sda_m = 1'b1;
        model_defaults();
        model_bad = 1'b0;
        #40;
        check_val("rst_oe", 32'(oe), 32'd0);
        check_val("rst_reg_wr", 32'(reg_wr), 32'd0);
        check_val("rst_reg_addr", 32'(reg_addr), 32'd0);
        check_val("rst_reg_data", 32'(reg_data), 32'd0);
        check_state();
        reset_n = 1'b1;
        #40;

        // Plain write R4 = 0x015
        do_write(7'h04, 9'h015);
        check_state();

        // Wrong device address: no ACK, no drive, no commit
        w0 = wr_cnt; o0 = oe_cnt;
        i2c_start();
        send_byte(8'h36, a); check_val("nack_dev", 32'(a), 32'd0);
        send_byte(8'h08, a); check_val("nack_b1", 32'(a), 32'd0);
        send_byte(8'h77, a); check_val("nack_b2", 32'(a), 32'd0);
        i2c_stop();
        check_val("nodrv_oe", 32'(oe_cnt - o0), 32'd0);
        check_val("nodrv_wr", 32'(wr_cnt - w0), 32'd0);
        check_state();

        // Reset-register write restores defaults
        do_write(7'h0F, 9'h000);
        check_state();
        check_val("R4_default", 32'(regs[44:36]), 32'h00A);

        // STOP before byte2 aborts
        w0 = wr_cnt;
        i2c_start();
        send_byte(8'h34, a);
        send_byte(8'h08, a);
        i2c_stop();
        check_val("abort_wr", 32'(wr_cnt - w0), 32'd0);
        check_state();

        // Unimplemented register
        do_write(7'h0C, 9'h0FF);
        check_state();

        // Third byte is not ACKed and causes no extra commit
        w0 = wr_cnt;
        i2c_start();
        send_byte(8'h34, a);
        send_byte(8'h04, a);
        exp_q.push_back({7'h02, 9'h055});
        send_byte(8'h55, a);
        send_byte(8'hAA, a);
        check_val("nack_b3", 32'(a), 32'd0);
        i2c_stop();
        check_val("b3_wr", 32'(wr_cnt - w0), 32'd1);
        model_regs[2] = 9'h055;
        check_state();

        // Repeated START mid-transfer restarts, data bit 8 set
        w0 = wr_cnt;
        i2c_start();
        send_byte(8'h34, a);
        send_byte(8'h0A, a);
        i2c_start();
        send_byte(8'h34, a);
        send_byte(8'h03, a);
        exp_q.push_back({7'h01, 9'h180});
        send_byte(8'h80, a);
        i2c_stop();
        check_val("rs_wr", 32'(wr_cnt - w0), 32'd1);
        model_regs[1] = 9'h180;
        check_state();

        // Reset asserted during ACK1
        do_write(7'h02, 9'h1FF);
        check_state();
        w0 = wr_cnt;
        i2c_start();
        send_byte(8'h34, a);
        send_bits(8'h08);
        sda_m = 1'b1; #(Q);
        scl = 1'b1;   #(Q);
        check_val("ack1_drive", 32'(oe), 32'd1);
        reset_n = 1'b0;
        #10;
        check_val("rst_release", 32'(oe), 32'd0);
        #10;
        reset_n = 1'b1;
        model_defaults();
        model_bad = 1'b0;
        scl = 1'b0; #(Q);
        i2c_stop();
        check_val("rst_abort_wr", 32'(wr_cnt - w0), 32'd0);
        check_state();
        do_write(7'h04, 9'h123);
        check_state();

        #1000;
        check_val("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_codec_regs.md
I2C_CODEC_REGS -- requirements
Module: i2c_codec_regs

Interface
REQ-001 The module SHALL have parameter DEV_ADDR, default 7'h1A, giving the 7-bit I2C target address it responds to.
REQ-002 The module SHALL have parameter NUM_REGS, default 10, giving the number of 9-bit codec registers, R0..R(NUM_REGS-1).
REQ-003 The module SHALL have port clk, input, 1 bit: the single system clock (main_clk domain, at least 20x SCLK rate).
REQ-004 The module SHALL have port reset_n, input, 1 bit: the reset, synchronous and active-low.
REQ-005 The module SHALL have port i2c_sclk, input, 1 bit: the bus clock, asynchronous to clk.
REQ-006 The module SHALL have port i2c_sdat_in, input, 1 bit: the bus data level, asynchronous to clk.
REQ-007 The module SHALL have port i2c_sdat_oe, output, 1 bit: the open-drain pull-low enable; 1 = drive SDAT low.
REQ-008 The module SHALL have port reg_wr, output, 1 bit: a one-clk pulse on each register commit.
REQ-009 The module SHALL have port reg_addr, output, 7 bits: the register address of the last commit.
REQ-010 The module SHALL have port reg_data, output, 9 bits: the data of the last commit.
REQ-011 The module SHALL have port regs, output, 9*NUM_REGS bits: the flat register file, with Rn at bits [9n+8:9n].
REQ-012 The module SHALL have port bad_addr, output, 1 bit: a sticky flag, set by a write to an unimplemented register.

Function
REQ-013 i2c_sclk and i2c_sdat_in SHALL each pass through a 2-flop synchronizer; all detection SHALL use the synchronized values plus a 1-cycle delayed copy.
REQ-014 START SHALL be a synchronized SDAT falling edge while SCLK is high; STOP SHALL be an SDAT rising edge while SCLK is high.
REQ-015 Data bits SHALL be sampled, MSB first, on the synchronized SCLK rising edge.
REQ-016 The FSM SHALL have states IDLE, DEVADDR, DEVACK, BYTE1, ACK1, BYTE2, ACK2, IGNORE.
REQ-017 START from any state SHALL enter DEVADDR, clear the bit counter, and release i2c_sdat_oe; repeated START SHALL be handled the same way.
REQ-018 STOP from any state SHALL enter IDLE and release i2c_sdat_oe.
REQ-019 After 8 bits in DEVADDR, if bits[7:1]==DEV_ADDR and bit0==0, the FSM SHALL go to DEVACK; otherwise (address mismatch or read request) it SHALL go to IGNORE and never drive SDAT.
REQ-020 In each ACK state, i2c_sdat_oe SHALL assert on the SCLK falling edge that ends bit 8 and SHALL release on the next SCLK falling edge.
REQ-021 Byte1 SHALL be {reg_addr[6:0], data[8]}; byte2 SHALL be data[7:0]; a transfer SHALL be DEVADDR, ACK, BYTE1, ACK1, BYTE2, ACK2.
REQ-022 Both byte1 and byte2 SHALL always be ACKed.
REQ-023 After ACK2 the FSM SHALL go to IGNORE; a third byte SHALL NOT be ACKed and SHALL cause no commit.
REQ-024 The commit SHALL occur in the clk cycle after the SCLK falling edge ending byte2 bit 8 is detected; reg_wr, reg_addr and reg_data SHALL update in that same cycle.
REQ-025 On commit with reg_addr < NUM_REGS, the module SHALL update Rn.
REQ-026 On commit with reg_addr == 7'h0F, the module SHALL load all registers with their defaults, independent of the data value.
REQ-027 On commit with any other reg_addr, the module SHALL set bad_addr and leave regs unchanged; reg_wr SHALL still pulse.
REQ-028 A START or STOP before byte2 completes SHALL abort the transfer with no commit and no register change.
REQ-029 Total latency from the pin-level SCLK falling edge to reg_wr SHALL be 4 clk cycles.

Reset
REQ-030 While reset_n==0 at a rising clk edge: FSM=IDLE, i2c_sdat_oe=0, reg_wr=0, reg_addr=0, reg_data=0, bad_addr=0, synchronizers=1 (bus idle), regs=defaults.
REQ-031 Reset asserted mid-transfer SHALL abort it with no commit, and SHALL release SDAT in the same cycle.
REQ-032 After reset_n rises, the module SHALL ignore the bus until a fresh START is seen.

Structure
REQ-033 Package codec_regs_pkg SHALL hold the state enum, the reset-register constant 7'h0F, and the default table R0..R9 = 097,097,079,079,00A,008,09F,00A,000,000 (hex).
REQ-034 Sub-module i2c_bus_sync SHALL contain the synchronizers plus the start, stop, rise and fall pulse detection; the FSM and register file SHALL stay in the top module.

Verification
REQ-035 Write 0x1A/W, 0x08, 0x15 -> three ACKs; reg_wr pulses once; reg_addr=0x04, reg_data=0x015, R4=0x015.
REQ-036 Device address 0x1B/W, then two bytes -> i2c_sdat_oe stays 0 throughout; no reg_wr; regs unchanged.
REQ-037 Write R4=0x015, then write 0x1E, 0x00 -> all registers return to defaults; R4=0x00A.
REQ-038 Write 0x1A/W, 0x08, then STOP before byte2 -> no commit; R4 stays 0x00A.
REQ-039 Write to reg 0x0C (bytes 0x18, 0xFF) -> ACKed; reg_wr pulses; bad_addr=1; regs unchanged.
REQ-040 Drive reset_n low during ACK1 -> i2c_sdat_oe=0 next cycle; regs=defaults; a following complete write commits normally.
